// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command packet parser: opcode encoding,
// packet framing constants and the parser state encoding.
package alu_pkg;

    // Header is opcode, reserved byte, then a 16-bit little-endian length.
    localparam int HDR_BYTES     = 4;
    // Every operand is carried as four little-endian bytes.
    localparam int OPERAND_BYTES = 4;
    localparam int LEN_W         = 16;

    typedef enum logic [7:0] {
        OP_ADD = 8'hA0,
        OP_SUB = 8'hA1,
        OP_MUL = 8'hA2,
        OP_DIV = 8'hA3
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RSVD,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_OPERAND,
        ST_EMIT,
        ST_DRAIN
    } state_e;

    // True when the byte names an operation the ALU datapath implements.
    function automatic logic opcode_known(input logic [7:0] op);
        logic known;
        known = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: known = 1'b1;
            default:                        known = 1'b0;
        endcase
        return known;
    endfunction

    // A header is accepted only for a known opcode carrying at least one
    // whole operand; anything else is drained as a malformed packet.
    function automatic logic header_ok(input logic [7:0] op, input logic [LEN_W-1:0] len);
        return opcode_known(op) && (len >= LEN_W'(HDR_BYTES + OPERAND_BYTES))
               && (len[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/alu_packet_parser.sv
// Parses framed command packets from the UART byte stream and emits one
// opcode-tagged 32-bit operand beat per operand to the ALU datapath.
// Malformed packets are drained byte by byte and flagged with err_o.
module alu_packet_parser
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH_P    = 8,
    parameter int OPERAND_WIDTH_P = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH_P-1:0]    s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [DATA_WIDTH_P-1:0]    m_opcode_o,
    output logic [OPERAND_WIDTH_P-1:0] m_operand_o,
    output logic                       m_first_o,
    output logic                       m_last_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic                       err_o
);

    localparam logic [1:0] LAST_IDX = 2'(OPERAND_BYTES - 1);

    state_e                  state;
    state_e                  next_state;
    logic [DATA_WIDTH_P-1:0] len_lo;
    logic [LEN_W-1:0]        remaining;
    logic [1:0]              byte_idx;
    logic                    xfer;
    logic                    retire;
    logic [LEN_W-1:0]        len_full;
    logic [LEN_W-1:0]        len_body;
    logic                    hdr_good;

    // The parser only stalls the byte stream while a beat waits for the ALU;
    // reset holds it off so no byte is consumed before the FSM is live.
    assign s_axis_tready = !rst && (state != ST_EMIT);
    assign xfer          = s_axis_tvalid && s_axis_tready;
    assign retire        = m_valid_o && m_ready_i;

    // The high length byte is on the bus during LEN_HI, so the full length
    // and its validity are evaluated combinationally from it.
    assign len_full = {s_axis_tdata, len_lo};
    assign len_body = (len_full >= LEN_W'(HDR_BYTES)) ? (len_full - LEN_W'(HDR_BYTES))
                                                      : '0;
    assign hdr_good = header_ok(m_opcode_o, len_full);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; header and operand states advance only on an accepted byte.
    always_comb begin
        // NOTE: default first, so no path through the case leaves next_state
        // unassigned and infers a latch.
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (xfer) next_state = ST_RSVD;
            end
            ST_RSVD: begin
                if (xfer) next_state = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (xfer) next_state = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    if (hdr_good) begin
                        next_state = ST_OPERAND;
                    end else if (len_body == '0) begin
                        next_state = ST_IDLE;
                    end else begin
                        next_state = ST_DRAIN;
                    end
                end
            end
            ST_OPERAND: begin
                if (xfer && (byte_idx == LAST_IDX)) next_state = ST_EMIT;
            end
            ST_EMIT: begin
                if (retire) next_state = m_last_o ? ST_IDLE : ST_OPERAND;
            end
            ST_DRAIN: begin
                if (xfer && (remaining == LEN_W'(1))) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Header capture, operand assembly, byte accounting and beat/err outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo      <= '0;
            remaining   <= '0;
            byte_idx    <= '0;
            m_opcode_o  <= '0;
            m_operand_o <= '0;
            m_first_o   <= 1'b0;
            m_last_o    <= 1'b0;
            m_valid_o   <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) m_opcode_o <= s_axis_tdata;
                end
                ST_LEN_LO: begin
                    if (xfer) len_lo <= s_axis_tdata;
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        remaining <= len_body;
                        if (hdr_good) begin
                            byte_idx  <= '0;
                            m_first_o <= 1'b1;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                ST_OPERAND: begin
                    if (xfer) begin
                        // First byte on the wire lands in the least significant lane.
                        m_operand_o[int'(byte_idx) * DATA_WIDTH_P +: DATA_WIDTH_P] <= s_axis_tdata;
                        remaining <= remaining - LEN_W'(1);
                        byte_idx  <= byte_idx + 2'd1;
                        if (byte_idx == LAST_IDX) begin
                            m_valid_o <= 1'b1;
                            m_last_o  <= (remaining == LEN_W'(1));
                        end
                    end
                end
                ST_EMIT: begin
                    if (retire) begin
                        m_valid_o <= 1'b0;
                        m_first_o <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (xfer) remaining <= remaining - LEN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_packet_parser.sv
// Self-checking bench for alu_packet_parser: directed packets plus a long
// randomized packet mix, checked every cycle against a packet-level model.
module tb_alu_packet_parser;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] data;
        logic        first;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  m_opcode_o;
    logic [31:0] m_operand_o;
    logic        m_first_o;
    logic        m_last_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic        err_o;

    beat_t       exp_q[$];
    beat_t       got_q[$];
    logic [31:0] fixed_ops[$];
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          exp_err   = 0;
    int          dut_err   = 0;
    int          stall_req = 0;
    bit          rand_ready = 1'b1;
    bit          gaps_on    = 1'b1;
    bit          prev_err   = 1'b0;

    always #5 clk = ~clk;

    alu_packet_parser dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_opcode_o    (m_opcode_o),
        .m_operand_o   (m_operand_o),
        .m_first_o     (m_first_o),
        .m_last_o      (m_last_o),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .err_o         (err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level rule: known opcode, at least one operand, whole operands only.
    function automatic bit model_ok(input logic [7:0] op, input logic [15:0] len);
        return (op inside {8'hA0, 8'hA1, 8'hA2, 8'hA3}) && (len >= 16'd8) && (len % 16'd4 == 16'd0);
    endfunction

    // Every-cycle comparison of the beat interface against the model queue.
    always @(negedge clk) begin
        if (rst) begin
            prev_err  = 1'b0;
            m_ready_i = 1'b0;
        end else begin
            if (err_o) begin
                dut_err++;
                check("err_with_valid", {31'b0, m_valid_o}, 32'd0);
                check("err_pulse_width", {31'b0, prev_err}, 32'd0);
            end
            prev_err = err_o;
            if (m_valid_o) begin
                check("tready_in_emit", {31'b0, s_axis_tready}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {31'b0, m_valid_o}, 32'd0);
                end else begin
                    check("beat_opcode", {24'b0, m_opcode_o}, {24'b0, exp_q[0].op});
                    check("beat_operand", m_operand_o, exp_q[0].data);
                    check("beat_first", {31'b0, m_first_o}, {31'b0, exp_q[0].first});
                    check("beat_last", {31'b0, m_last_o}, {31'b0, exp_q[0].last});
                end
                if (stall_req > 0) begin
                    m_ready_i = 1'b0;
                    stall_req--;
                end else begin
                    m_ready_i = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                if (m_ready_i && exp_q.size() > 0) begin
                    got_q.push_back('{m_opcode_o, m_operand_o, m_first_o, m_last_o});
                    void'(exp_q.pop_front());
                end
            end else begin
                check("tready_outside_emit", {31'b0, s_axis_tready}, 32'd1);
                m_ready_i = 1'($urandom_range(0, 1));
            end
        end
    end

    // Present one byte and hold it until the parser takes it (called at a negedge).
    task automatic send_byte(input logic [7:0] b);
        int waited;
        if (gaps_on) begin
            repeat ($urandom_range(0, 2)) begin
                s_axis_tvalid = 1'b0;
                @(negedge clk);
            end
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b;
        waited = 0;
        while (!s_axis_tready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 300) check("tready_timeout", {31'b0, s_axis_tready}, 32'd1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    // Build a packet, record what it must produce, then stream it in.
    task automatic send_packet(input logic [7:0] op, input logic [15:0] len);
        bit          ok;
        int          body;
        int          nops;
        logic [31:0] words[$];
        ok   = model_ok(op, len);
        body = (len >= 16'd4) ? int'(len) - 4 : 0;
        if (ok) begin
            nops = body / 4;
            for (int i = 0; i < nops; i++) begin
                logic [31:0] w;
                w = (i < fixed_ops.size()) ? fixed_ops[i] : $urandom;
                words.push_back(w);
                exp_q.push_back('{op, w, (i == 0), (i == nops - 1)});
            end
        end else begin
            exp_err++;
        end
        send_byte(op);
        send_byte(8'($urandom));
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        if (ok) begin
            foreach (words[i]) begin
                for (int k = 0; k < 4; k++) send_byte(words[i][k*8 +: 8]);
            end
        end else begin
            for (int i = 0; i < body; i++) send_byte(8'($urandom));
        end
    endtask

    // Wait for all modelled beats to retire, then compare beat and error accounting.
    task automatic checkpoint(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        check({name, "_beats_pending"}, exp_q.size(), 32'd0);
        check({name, "_err_count"}, dut_err, exp_err);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_valid"}, {31'b0, m_valid_o}, 32'd0);
        check({name, "_first"}, {31'b0, m_first_o}, 32'd0);
        check({name, "_last"}, {31'b0, m_last_o}, 32'd0);
        check({name, "_err"}, {31'b0, err_o}, 32'd0);
        check({name, "_opcode"}, {24'b0, m_opcode_o}, 32'd0);
        check({name, "_operand"}, m_operand_o, 32'd0);
        check({name, "_tready"}, {31'b0, s_axis_tready}, 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        m_ready_i     = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("tready_after_reset", {31'b0, s_axis_tready}, 32'd1);

        // ADD with two literal operands; the retired beats are pinned by hand.
        got_q.delete();
        fixed_ops = '{32'h0000_0001, 32'h0000_0002};
        send_packet(8'hA0, 16'h000C);
        fixed_ops.delete();
        checkpoint("add2");
        check("add2_beat_count", got_q.size(), 32'd2);
        if (got_q.size() == 2) begin
            check("add2_b0_op", {24'b0, got_q[0].op}, 32'h0000_00A0);
            check("add2_b0_data", got_q[0].data, 32'h0000_0001);
            check("add2_b0_first", {31'b0, got_q[0].first}, 32'd1);
            check("add2_b0_last", {31'b0, got_q[0].last}, 32'd0);
            check("add2_b1_data", got_q[1].data, 32'h0000_0002);
            check("add2_b1_first", {31'b0, got_q[1].first}, 32'd0);
            check("add2_b1_last", {31'b0, got_q[1].last}, 32'd1);
        end
        check("add2_no_err", dut_err, 32'd0);

        // MUL single beat held for five cycles of back-pressure.
        rand_ready = 1'b0;
        stall_req  = 5;
        send_packet(8'hA2, 16'h0008);
        checkpoint("mul_stall");
        check("mul_stall_consumed", stall_req, 32'd0);
        rand_ready = 1'b1;

        // Length not a multiple of four, followed by a good SUB packet.
        send_packet(8'hA0, 16'h000A);
        send_packet(8'hA1, 16'h0010);
        checkpoint("badlen_then_sub");

        // Unknown opcode is drained with no beat.
        send_packet(8'h55, 16'h0008);
        checkpoint("bad_opcode");

        // Reset mid-operand: outputs clear asynchronously, partial packet discarded.
        send_byte(8'hA0);
        send_byte(8'h00);
        send_byte(8'h0C);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_packet(8'hA3, 16'h000C);
        checkpoint("after_reset");

        // Short lengths return straight to IDLE; the next byte is an opcode.
        send_packet(8'hA0, 16'h0003);
        send_packet(8'hA1, 16'h0008);
        send_packet(8'hA2, 16'h0004);
        send_packet(8'hA0, 16'h000C);
        checkpoint("short_len");

        // Randomized mix of good and malformed packets with random back-pressure.
        for (int p = 0; p < 150; p++) begin
            logic [7:0]  op;
            logic [15:0] len;
            op  = ($urandom_range(0, 99) < 85) ? 8'(8'hA0 + $urandom_range(0, 3)) : 8'($urandom);
            len = ($urandom_range(0, 99) < 80) ? 16'(4 * $urandom_range(2, 8))
                                               : 16'($urandom_range(0, 40));
            gaps_on = ($urandom_range(0, 3) != 0);
            send_packet(op, len);
        end
        gaps_on = 1'b1;
        checkpoint("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
